// File: rtl/alu_share_arb_pkg.sv
// Shared types and constants for the two-requester ALU sharing arbiter.
package alu_share_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ALUC_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [ALUC_W-1:0] ALUC_ADD = 4'b0000;
  localparam logic [ALUC_W-1:0] ALUC_SUB = 4'b0100;
  localparam logic [ALUC_W-1:0] ALUC_AND = 4'b0001;
  localparam logic [ALUC_W-1:0] ALUC_OR  = 4'b0101;
  localparam logic [ALUC_W-1:0] ALUC_XOR = 4'b0010;
  localparam logic [ALUC_W-1:0] ALUC_LUI = 4'b0110;
  localparam logic [ALUC_W-1:0] ALUC_SLL = 4'b0011;
  localparam logic [ALUC_W-1:0] ALUC_SRL = 4'b0111;
  localparam logic [ALUC_W-1:0] ALUC_SRA = 4'b1111;

  // Captured operation: owner ID plus the ALU inputs.
  typedef struct packed {
    logic              id;
    logic [ALUC_W-1:0] aluc;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } op_t;

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU: add/sub, and/or, xor/lui, shifts (amount from a[4:0]).
module alu
  import alu_share_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ALUC_W-1:0] aluc,
  output logic [DATA_W-1:0] r,
  output logic              z
);

  // aluc[1:0] picks the unit, aluc[2] the variant, aluc[3] arithmetic vs logical right shift.
  always_comb begin
    r = '0;
    case (aluc[1:0])
      2'b00: r = aluc[2] ? (a - b) : (a + b);
      2'b01: r = aluc[2] ? (a | b) : (a & b);
      2'b10: r = aluc[2] ? {b[15:0], 16'h0000} : (a ^ b);
      2'b11: begin
        if (!aluc[2])
          r = b << a[4:0];
        else if (aluc[3])
          r = $signed(b) >>> a[4:0];
        else
          r = b >> a[4:0];
      end
      default: r = '0;
    endcase
  end

  assign z = (r == '0);

endmodule

// File: rtl/alu_share_arb.sv
// Two-requester arbiter/sequencer sharing one ALU: IDLE grant -> EXEC -> RESP handshake.
// Build option: define ALU_SHARE_ARB_RR_EN for round-robin ties; otherwise requester 0 has priority.
module alu_share_arb
  import alu_share_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ALUC_W-1:0] aluc0,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ALUC_W-1:0] aluc1,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic              gnt1,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_r,
  output logic              rsp_z,
  input  logic              rsp_ready
);

  state_t            state;
  state_t            state_next;
  op_t               op;
  op_t               op_sel;
  logic              sel1;
  logic              grant;
  logic              rsp_load;
  logic              rsp_clear;
  logic [DATA_W-1:0] alu_r;
  logic              alu_z;

`ifdef ALU_SHARE_ARB_RR_EN
  // Pointer holds the last winner; on a tie the other requester wins.
  logic ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= 1'b1;
    else if (grant)
      ptr <= sel1;
  end

  assign sel1 = req1 && (!req0 || !ptr);
`else
  assign sel1 = req1 && !req0;
`endif

  always_comb begin
    op_sel = '0;
    if (sel1) begin
      op_sel.id   = 1'b1;
      op_sel.aluc = aluc1;
      op_sel.a    = a1;
      op_sel.b    = b1;
    end else begin
      op_sel.id   = 1'b0;
      op_sel.aluc = aluc0;
      op_sel.a    = a0;
      op_sel.b    = b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Grants are combinational and only ever issued from IDLE outside reset.
  always_comb begin
    state_next = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    grant      = 1'b0;
    rsp_load   = 1'b0;
    rsp_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (req0 || req1)) begin
          grant      = 1'b1;
          gnt0       = !sel1;
          gnt1       = sel1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        rsp_load   = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_clear  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  alu u_alu (
    .a    (op.a),
    .b    (op.b),
    .aluc (op.aluc),
    .r    (alu_r),
    .z    (alu_z)
  );

  // Op capture on grant; response registers load from the ALU in EXEC and hold in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op        <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_r     <= '0;
      rsp_z     <= 1'b0;
    end else begin
      if (grant)
        op <= op_sel;
      if (rsp_load) begin
        rsp_valid <= 1'b1;
        rsp_id    <= op.id;
        rsp_r     <= alu_r;
        rsp_z     <= alu_z;
      end else if (rsp_clear) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios then randomized traffic vs a transaction model.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, gnt0, gnt1;
  logic [3:0]  aluc0, aluc1;
  logic [31:0] a0, b0, a1, b1;
  logic        rsp_valid, rsp_id, rsp_z, rsp_ready;
  logic [31:0] rsp_r;

  int errors = 0;
  int checks = 0;

`ifdef ALU_SHARE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [3:0] C_ADD = 4'b0000, C_SUB = 4'b0100, C_AND = 4'b0001,
                         C_OR  = 4'b0101, C_XOR = 4'b0010, C_LUI = 4'b0110,
                         C_SLL = 4'b0011, C_SRL = 4'b0111, C_SRA = 4'b1111;

  logic [3:0] codes [9] = '{C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_LUI, C_SLL, C_SRL, C_SRA};

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .aluc0     (aluc0),
    .a0        (a0),
    .b0        (b0),
    .gnt0      (gnt0),
    .req1      (req1),
    .aluc1     (aluc1),
    .a1        (a1),
    .b1        (b1),
    .gnt1      (gnt1),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_r     (rsp_r),
    .rsp_z     (rsp_z),
    .rsp_ready (rsp_ready)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = a[4:0];
    case (c)
      C_ADD:   return a + b;
      C_SUB:   return a - b;
      C_AND:   return a & b;
      C_OR:    return a | b;
      C_XOR:   return a ^ b;
      C_LUI:   return {b[15:0], 16'h0000};
      C_SLL:   return b << sh;
      C_SRL:   return b >> sh;
      C_SRA:   return 32'($signed(b) >>> sh);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete operation from an idle block with rsp_ready held high.
  task automatic do_op(input bit id, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input bit ez,
                       input string tag);
    if (id) begin req1 = 1'b1; aluc1 = c; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; aluc0 = c; a0 = a; b0 = b; end
    rsp_ready = 1'b1;
    #1;
    chk1({tag, ".gnt0"}, gnt0, !id);
    chk1({tag, ".gnt1"}, gnt1, id);
    tick;
    if (id) req1 = 1'b0; else req0 = 1'b0;
    chk1({tag, ".exec_valid"}, rsp_valid, 1'b0);
    #1;
    chk1({tag, ".exec_nogrant"}, gnt0 | gnt1, 1'b0);
    tick;
    chk1({tag, ".valid"}, rsp_valid, 1'b1);
    chk1({tag, ".id"}, rsp_id, id);
    chk32({tag, ".r"}, rsp_r, er);
    chk1({tag, ".z"}, rsp_z, ez);
    tick;
    chk1({tag, ".drop"}, rsp_valid, 1'b0);
  endtask

  initial begin
    bit          act [2];
    logic [3:0]  mc [2];
    logic [31:0] ma [2], mb [2];
    bit          busy, last, eid, ez, w, g, ev;
    int          gcyc;
    logic [31:0] er;

    rst = 1'b1; rsp_ready = 1'b1;
    req0 = 1'b1; aluc0 = C_ADD; a0 = 32'd5; b0 = 32'd7;
    req1 = 1'b0; aluc1 = '0; a1 = '0; b1 = '0;
    tick; tick;
    chk1("rst.valid", rsp_valid, 1'b0);
    chk1("rst.id", rsp_id, 1'b0);
    chk32("rst.r", rsp_r, 32'h0);
    chk1("rst.z", rsp_z, 1'b0);
    chk1("rst.gnt0", gnt0, 1'b0);
    chk1("rst.gnt1", gnt1, 1'b0);
    rst = 1'b0;

    do_op(1'b0, C_ADD, 32'd5, 32'd7, 32'd12, 1'b0, "add");
    do_op(1'b1, C_SUB, 32'd9, 32'd9, 32'd0, 1'b1, "sub_zero");
    do_op(1'b0, C_SRA, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0, "sra");
    do_op(1'b1, C_SRL, 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b0, "srl");
    do_op(1'b0, C_LUI, 32'h55, 32'h0000_1234, 32'h1234_0000, 1'b0, "lui");

    // Contention from reset: both requesters held high.
    rst = 1'b1;
    tick;
    req0 = 1'b1; aluc0 = C_ADD; a0 = 32'd1;  b0 = 32'd2;
    req1 = 1'b1; aluc1 = C_SUB; a1 = 32'd10; b1 = 32'd3;
    rsp_ready = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      w = RR ? 1'((k / 3) % 2) : 1'b0;
      g = (k % 3 == 0);
      chk1("cont.valid", rsp_valid, k % 3 == 2);
      if (k % 3 == 2) begin
        chk1("cont.id", rsp_id, w);
        chk32("cont.r", rsp_r, w ? 32'd7 : 32'd3);
      end
      #1;
      chk1("cont.gnt0", gnt0, g && !w);
      chk1("cont.gnt1", gnt1, g && w);
      tick;
    end
    req0 = 1'b0; req1 = 1'b0;

    // Backpressure with requester 1 arriving while busy.
    req0 = 1'b1; aluc0 = C_XOR; a0 = 32'h0000_ff00; b0 = 32'h0000_0ff0;
    rsp_ready = 1'b0;
    #1;
    chk1("bp.gnt0", gnt0, 1'b1);
    tick;
    req0 = 1'b0;
    req1 = 1'b1; aluc1 = C_AND; a1 = 32'hf0; b1 = 32'h3c;
    #1;
    chk1("bp.exec_gnt1", gnt1, 1'b0);
    tick;
    for (int i = 0; i < 5; i++) begin
      chk1("bp.valid", rsp_valid, 1'b1);
      chk1("bp.id", rsp_id, 1'b0);
      chk32("bp.r", rsp_r, 32'h0000_f0f0);
      chk1("bp.z", rsp_z, 1'b0);
      #1;
      chk1("bp.nogrant", gnt0 | gnt1, 1'b0);
      tick;
    end
    rsp_ready = 1'b1;
    chk1("bp.held", rsp_valid, 1'b1);
    tick;
    chk1("bp.drop", rsp_valid, 1'b0);
    do_op(1'b1, C_AND, 32'hf0, 32'h3c, 32'h30, 1'b0, "bp_and");

    // Reset pulsed asynchronously during EXEC.
    req0 = 1'b1; aluc0 = C_ADD; a0 = 32'd1; b0 = 32'd1;
    #1;
    chk1("rexec.gnt0", gnt0, 1'b1);
    tick;
    req0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk1("rexec.valid", rsp_valid, 1'b0);
    rst = 1'b0;
    do_op(1'b0, C_ADD, 32'd20, 32'd22, 32'd42, 1'b0, "after_rst");

    // Randomized traffic against a transaction-level model.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    act[0] = 1'b0; act[1] = 1'b0;
    mc[0] = '0; mc[1] = '0; ma[0] = '0; ma[1] = '0; mb[0] = '0; mb[1] = '0;
    busy = 1'b0; last = 1'b1; gcyc = 0; eid = 1'b0; er = '0; ez = 1'b0;
    for (int k = 0; k < 600; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!act[r] && $urandom_range(0, 2) == 0) begin
          act[r] = 1'b1;
          mc[r]  = codes[$urandom_range(0, 8)];
          ma[r]  = $urandom;
          mb[r]  = ($urandom_range(0, 3) == 0) ? ma[r] : 32'($urandom);
        end else if (act[r] && $urandom_range(0, 19) == 0) begin
          act[r] = 1'b0;
        end
      end
      req0 = act[0]; aluc0 = mc[0]; a0 = ma[0]; b0 = mb[0];
      req1 = act[1]; aluc1 = mc[1]; a1 = ma[1]; b1 = mb[1];
      rsp_ready = ($urandom_range(0, 2) != 0);

      ev = busy && (k >= gcyc + 2);
      chk1("rnd.valid", rsp_valid, ev);
      if (ev) begin
        chk1("rnd.id", rsp_id, eid);
        chk32("rnd.r", rsp_r, er);
        chk1("rnd.z", rsp_z, ez);
      end
      #1;
      g = !busy && (act[0] || act[1]);
      w = (act[0] && act[1]) ? (RR ? !last : 1'b0) : act[1];
      chk1("rnd.gnt0", gnt0, g && !w);
      chk1("rnd.gnt1", gnt1, g && w);
      if (g) begin
        busy = 1'b1;
        gcyc = k;
        last = w;
        eid  = w;
        er   = ref_alu(mc[w], ma[w], mb[w]);
        ez   = (er == 32'h0);
        act[w] = 1'b0;
      end else if (ev && rsp_ready) begin
        busy = 1'b0;
      end
      tick;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer for the 32-bit ALU. It lets two independent clients (for example the main datapath and a multi-cycle helper unit) share one `alu` instance. Requests are accepted one at a time, the operation is executed in a registered execute stage, and the result is returned with a valid/ready response handshake tagged with the requester ID.

## Interface
Parameters: none. Data width is fixed at 32 and the ALU control width at 4.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0` in 1: requester 0 has an operation pending. It holds `req0`, `aluc0`, `a0` and `b0` stable until `gnt0`.
- `aluc0` in 4: ALU control code for requester 0.
- `a0`, `b0` in 32 each: operands for requester 0.
- `gnt0` out 1: requester 0's operands are captured at this clock edge.
- `req1`, `aluc1`, `a1`, `b1`, `gnt1`: same as the requester 0 ports, for requester 1.
- `rsp_valid` out 1: a result is available.
- `rsp_id` out 1: which requester the result belongs to.
- `rsp_r` out 32: ALU result.
- `rsp_z` out 1: ALU zero flag, asserted when `rsp_r == 0`.
- `rsp_ready` in 1: the consumer accepts the response.

## Operation
- FSM with three states: IDLE, EXEC, RESP.
- IDLE:
  - If `req0` or `req1` is high, the winner's `gntN` is asserted combinationally in the same cycle.
  - At that edge, the winner's aluc, a and b are latched into the op registers and the state moves to EXEC.
  - With no request, the FSM stays in IDLE.
- EXEC:
  - The ALU computes from the op registers.
  - At the edge, r and z are registered into `rsp_r` and `rsp_z`, `rsp_id` is set, `rsp_valid` goes to 1, and the state moves to RESP.
- RESP:
  - `rsp_*` are held stable while `rsp_ready` = 0.
  - When `rsp_valid && rsp_ready`, `rsp_valid` drops at the edge and the state returns to IDLE.
  - No grant is issued in EXEC or RESP.
- At most one `gntN` is high in any cycle. `gnt0` and `gnt1` are both 0 outside IDLE.
- Arithmetic follows ALU semantics exactly:
  - add/sub wrap modulo 2^32 with no overflow flag.
  - Shifts operate on b, with the shift amount taken from a[4:0].
  - LUI returns {b[15:0],16'h0}.
- ALU codes: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111.
- Any other code is passed through unchanged; the result is whatever the ALU produces for it.

## Timing
- Reset values: state IDLE, `rsp_valid` 0, `rsp_id` 0, `rsp_r` 0, `rsp_z` 0, op registers 0, round-robin pointer = 1 (so requester 0 wins the first tie).
- `gnt0` and `gnt1` are 0 while `rst` is high.
- Latency: a grant in cycle N gives `rsp_valid` high in cycle N+2.
- Throughput: at most one operation every 3 cycles. The interval is longer when `rsp_ready` is held low.
- A request arriving while the block is in EXEC or RESP waits. Its `req` must remain high; it is considered in the first IDLE cycle.
- A requester may drop `req` before it is granted. No state is kept for a dropped request.
- Reset asserted mid-operation (EXEC or RESP) returns the block to the reset values immediately:
  - The in-flight result is discarded and never presented.
  - The requester whose operation was lost must re-request.
- Arbitration when both requests are high in IDLE:
  - With round-robin compiled in, the requester not equal to the pointer wins.
  - The pointer is updated to the winner on every grant.

## Configuration
- Macro `ALU_SHARE_ARB_RR_EN`.
- Defined: round-robin arbitration as described in Timing. Under continuous contention, grants alternate 0,1,0,1.
- Undefined: fixed priority, where requester 0 always wins a tie. The pointer register is not implemented and requester 1 can starve.
- Both builds keep identical ports and identical latency.

## Structure
- Shared package `alu_share_arb_pkg` contains:
  - the state encoding (IDLE/EXEC/RESP as 2-bit constants);
  - the ALU control constants listed above;
  - width constants DATA_W = 32 and ALUC_W = 4.
- One sub-module: the existing `alu`, instantiated once. It is driven from the op registers; its r and z outputs feed the response registers.
- The arbiter logic and the FSM live in the top module.

## Test plan
- Single requester: `req0` with ADD, a=5, b=7 gives `gnt0` in cycle 0, then in cycle 2 `rsp_valid`=1, `rsp_id`=0, `rsp_r`=12, `rsp_z`=0.
- Zero flag: `req1` with SUB, a=9, b=9 gives `rsp_r`=0, `rsp_z`=1, `rsp_id`=1.
- Contention: `req0` and `req1` both held high from reset with `rsp_ready`=1:
  - RR build: grant order 0,1,0,1, with grants every 3 cycles.
  - Fixed-priority build: grant order 0,0,0,0.
- Backpressure: `rsp_ready` held 0 for 5 cycles after `rsp_valid` rises.
  - `rsp_*` must not change and no `gnt` may be issued during that time.
  - After `rsp_ready` returns to 1, `rsp_valid` drops at the next edge.
- Shifter and LUI:
  - SRA with a=4, b=32'h8000_0000 gives 32'hF800_0000.
  - SRL with the same operands gives 32'h0800_0000.
  - LUI with b=32'h0000_1234 gives 32'h1234_0000.
- Reset in EXEC: `rst` pulsed asynchronously mid-cycle during EXEC.
  - `rsp_valid` stays 0 and no response for that operation ever appears.
  - The next `req0` is granted in the first IDLE cycle after reset deasserts.
